// File: rtl/kserial_adder.sv
// Digit-serial adder: sum = a + b + c_in, DIGIT bits per cycle, LSB digit first.
// Latency: result valid N edges after the accept edge (N = WIDTH/DIGIT), N+2 cycles per op.
// Backpressure: result held in DONE until out_ready; operands accepted only in IDLE.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (a, b, c_in sampled on the accept edge)
//   out_valid/out_ready   result handshake (sum, c_out stable while out_valid)
//   busy                  high while an operation is in CALC or DONE
module kserial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("kserial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dsum;
    logic             accept;

    // One digit of the ripple: low DIGIT bits of both shift registers plus the carry.
    always_comb begin
        dsum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Return to IDLE only; a new accept needs a separate IDLE cycle.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == CALC) begin
            // Operands shift right so the current digit is always at bit 0.
            a_sh                         <= a_sh >> DIGIT;
            b_sh                         <= b_sh >> DIGIT;
            sum[int'(cnt)*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
            carry                        <= dsum[DIGIT];
            cnt                          <= cnt + CW'(1);
            if (cnt == LAST) begin
                c_out <= dsum[DIGIT];
            end
        end
    end

endmodule

// File: tb/tb_kserial_adder.sv
// Directed bench for kserial_adder across four parameter sets:
// 8x1 (basic, reset mid-op, back-to-back), 3x1 (exhaustive), 4x4 (single digit), 8x2 (backpressure).
module tb_kserial_adder;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_total;
    int   n_pass;

    // WIDTH=8, DIGIT=1
    logic       iv8, ir8, ov8, or8, ci8, co8, bz8;
    logic [7:0] a8, b8, s8;
    // WIDTH=3, DIGIT=1
    logic       iv3, ir3, ov3, or3, ci3, co3, bz3;
    logic [2:0] a3, b3, s3;
    // WIDTH=4, DIGIT=4
    logic       iv4, ir4, ov4, or4, ci4, co4, bz4;
    logic [3:0] a4, b4, s4;
    // WIDTH=8, DIGIT=2
    logic       iv82, ir82, ov82, or82, ci82, co82, bz82;
    logic [7:0] a82, b82, s82;

    kserial_adder #(.WIDTH(8), .DIGIT(1)) u_8x1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .c_in(ci8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .c_out(co8), .busy(bz8));

    kserial_adder #(.WIDTH(3), .DIGIT(1)) u_3x1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3), .c_in(ci3),
        .out_valid(ov3), .out_ready(or3), .sum(s3), .c_out(co3), .busy(bz3));

    kserial_adder #(.WIDTH(4), .DIGIT(4)) u_4x4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .c_in(ci4),
        .out_valid(ov4), .out_ready(or4), .sum(s4), .c_out(co4), .busy(bz4));

    kserial_adder #(.WIDTH(8), .DIGIT(2)) u_8x2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv82), .in_ready(ir82), .a(a82), .b(b82), .c_in(ci82),
        .out_valid(ov82), .out_ready(or82), .sum(s82), .c_out(co82), .busy(bz82));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation on the 8x1 instance. lat counts edges from the accept edge
    // (inclusive) to the edge after which out_valid is seen high.
    task automatic op8(input logic [7:0] va, input logic [7:0] vb, input logic vc, output int lat);
        int w;
        a8 = va; b8 = vb; ci8 = vc; iv8 = 1'b1;
        w = 0;
        while (!ir8 && w < 40) begin
            @(posedge clk); #1; w++;
        end
        check("op8_in_ready", {31'd0, ir8}, 32'd1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        check("op8_busy_calc", {31'd0, bz8}, 32'd1);
        lat = 1;
        while (!ov8 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int w;
        int prev_acc;
        int acc;
        logic [7:0] va_t [4];
        logic [7:0] vb_t [4];
        logic       vc_t [4];
        logic [8:0] ve_t [4];
        logic [3:0] e3;

        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0;
        iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; or8 = 1;
        iv3 = 0; a3 = 0; b3 = 0; ci3 = 0; or3 = 1;
        iv4 = 0; a4 = 0; b4 = 0; ci4 = 0; or4 = 1;
        iv82 = 0; a82 = 0; b82 = 0; ci82 = 0; or82 = 0;

        // Reset state
        #1;
        check("rst_in_ready", {31'd0, ir8}, 32'd1);
        check("rst_out_valid", {31'd0, ov8}, 32'd0);
        check("rst_busy", {31'd0, bz8}, 32'd0);
        check("rst_sum", {24'd0, s8}, 32'd0);
        check("rst_c_out", {31'd0, co8}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: 0xFF + 0x01 + 0 over 8 single-bit digits
        op8(8'hFF, 8'h01, 1'b0, lat);
        check("t1_latency", lat, 32'd9);
        check("t1_sum", {24'd0, s8}, 32'h00);
        check("t1_c_out", {31'd0, co8}, 32'd1);
        check("t1_busy_done", {31'd0, bz8}, 32'd1);
        @(posedge clk); #1;
        check("t1_idle_after", {31'd0, ir8}, 32'd1);

        // T2: exhaustive 3-bit operands
        for (int v = 0; v < 128; v++) begin
            a3 = v[2:0]; b3 = v[5:3]; ci3 = v[6]; iv3 = 1'b1;
            w = 0;
            while (!ir3 && w < 20) begin
                @(posedge clk); #1; w++;
            end
            @(posedge clk); #1;
            iv3 = 1'b0;
            w = 0;
            while (!ov3 && w < 20) begin
                @(posedge clk); #1; w++;
            end
            e3 = {1'b0, v[2:0]} + {1'b0, v[5:3]} + {3'd0, v[6]};
            check($sformatf("t2_%0d+%0d+%0d", v[2:0], v[5:3], v[6]), {28'd0, co3, s3}, {28'd0, e3});
        end

        // T3: single-digit configuration, 9 + 8 + 1 = 0x12
        a4 = 4'h9; b4 = 4'h8; ci4 = 1'b1; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("t3_latency", lat, 32'd2);
        check("t3_sum", {28'd0, s4}, 32'h2);
        check("t3_c_out", {31'd0, co4}, 32'd1);

        // T4: backpressure on 8x2, 0xA5 + 0x5A + 1 = 0x100
        a82 = 8'hA5; b82 = 8'h5A; ci82 = 1'b1; iv82 = 1'b1;
        @(posedge clk); #1;
        iv82 = 1'b0;
        lat = 1;
        while (!ov82 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("t4_latency", lat, 32'd5);
        check("t4_sum", {24'd0, s82}, 32'h00);
        check("t4_c_out", {31'd0, co82}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            iv82 = (k % 2 == 0);
            a82 = 8'h11 * k[7:0]; b82 = 8'h33; ci82 = 1'b0;
            @(posedge clk); #1;
            check($sformatf("t4_hold_valid_%0d", k), {31'd0, ov82}, 32'd1);
            check($sformatf("t4_hold_ready_%0d", k), {31'd0, ir82}, 32'd0);
            check($sformatf("t4_hold_sum_%0d", k), {23'd0, co82, s82}, 32'h100);
        end
        // in_valid high on the handshake edge must not be taken in DONE
        iv82 = 1'b1; or82 = 1'b1;
        @(posedge clk); #1;
        iv82 = 1'b0;
        check("t4_release_valid", {31'd0, ov82}, 32'd0);
        check("t4_release_ready", {31'd0, ir82}, 32'd1);
        check("t4_release_busy", {31'd0, bz82}, 32'd0);
        check("t4_sum_kept", {23'd0, co82, s82}, 32'h100);

        // T5: reset during CALC at cnt=3
        a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_in_ready", {31'd0, ir8}, 32'd1);
        check("t5_rst_out_valid", {31'd0, ov8}, 32'd0);
        check("t5_rst_busy", {31'd0, bz8}, 32'd0);
        check("t5_rst_sum", {23'd0, co8, s8}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'h10, 8'h20, 1'b0, lat);
        check("t5_after_latency", lat, 32'd9);
        check("t5_after_sum", {23'd0, co8, s8}, 32'h030);

        // T6: back-to-back with in_valid held high; accepts spaced N+2 = 10 cycles
        va_t[0] = 8'h12; vb_t[0] = 8'h34; vc_t[0] = 1'b0; ve_t[0] = 9'h046;
        va_t[1] = 8'hF0; vb_t[1] = 8'h0F; vc_t[1] = 1'b1; ve_t[1] = 9'h100;
        va_t[2] = 8'h80; vb_t[2] = 8'h80; vc_t[2] = 1'b0; ve_t[2] = 9'h100;
        va_t[3] = 8'h7F; vb_t[3] = 8'h00; vc_t[3] = 1'b1; ve_t[3] = 9'h080;
        @(posedge clk); #1;
        iv8 = 1'b1; or8 = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            a8 = va_t[i]; b8 = vb_t[i]; ci8 = vc_t[i];
            w = 0;
            while (!ir8 && w < 40) begin
                @(posedge clk); #1; w++;
            end
            @(posedge clk); #1;
            acc = cyc;
            if (i > 0) check($sformatf("t6_spacing_%0d", i), acc - prev_acc, 32'd10);
            prev_acc = acc;
            w = 0;
            while (!ov8 && w < 40) begin
                @(posedge clk); #1; w++;
            end
            check($sformatf("t6_result_%0d", i), {23'd0, co8, s8}, {23'd0, ve_t[i]});
        end
        iv8 = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
